// File: rtl/cal_unit.sv
// -----------------------------------------------------------------------------
// cal_unit
//
// Calculation-stage responder for a four-state controller
// (Sinit=0, Smem=1, Scal=2, Sdisplay=3). The unit watches the controller
// state, reports its own status on CS, and runs one unsigned W-bit operation
// each time the controller enters Scal. The result is held for the display
// stage.
//
//   op 00 add : one busy cycle, zero-extended (W+1)-bit sum
//   op 01 sub : one busy cycle, 2W-bit two's-complement difference
//   op 10 mul : W busy cycles, shift-add, multiplier LSB first
//   op 11 div : W busy cycles, restoring, quotient MSB first;
//               result = {remainder, quotient}. Divide by zero takes one
//               busy cycle and gives all ones with err=1.
//
// Ports
//   clk    in  1   rising-edge clock
//   rst    in  1   asynchronous reset, active low
//   state  in  2   controller state
//   op     in  2   operation select (sampled on the start edge only)
//   a, b   in  W   operands (sampled on the start edge only)
//   CS     out 2   status: 00 idle, 01 ready, 11 busy, 10 done
//   result out 2W  operation result (registered)
//   err    out 1   divide-by-zero flag (registered)
//
// Handshake: the unit accepts a start only in READY on an edge where
// state==Scal, and it only leaves DONE after state==Sinit, so each Scal
// visit of the controller produces exactly one computation.
// -----------------------------------------------------------------------------
module cal_unit #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [1:0]     state,
    input  logic [1:0]     op,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [1:0]     CS,
    output logic [2*W-1:0] result,
    output logic           err
);

    localparam int CW = $clog2(W) + 1;

    localparam logic [1:0] S_INIT = 2'd0;
    localparam logic [1:0] S_CAL  = 2'd2;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    // State encoding equals the CS code, so CS is the state register itself
    // and is registered by construction.
    typedef enum logic [1:0] {
        U_IDLE  = 2'b00,
        U_READY = 2'b01,
        U_BUSY  = 2'b11,
        U_DONE  = 2'b10
    } u_state_t;

    u_state_t r_fsm;
    u_state_t w_fsm_next;

    logic [1:0]     r_op;
    logic [W-1:0]   r_b;      // latched B (addend/subtrahend/divisor)
    logic [2*W-1:0] r_x;      // low half: latched A; mul: shifted multiplicand
    logic [W-1:0]   r_y;      // mul: multiplier shifter; div: dividend/quotient
    logic [2*W-1:0] r_acc;    // mul partial product
    logic [W-1:0]   r_rem;    // div partial remainder
    logic [CW-1:0]  r_cnt;    // busy edges completed for mul/div
    logic [2*W-1:0] r_result;
    logic           r_err;

    logic           w_start;
    logic           w_abort;
    logic           w_last;
    logic           w_div0;
    logic [W:0]     w_sum;
    logic [2*W-1:0] w_diff;
    logic [2*W-1:0] w_acc_next;
    logic [W:0]     w_rem_sh;
    logic [W:0]     w_trial;
    logic           w_qbit;
    logic [W-1:0]   w_rem_next;
    logic [W-1:0]   w_q_next;

    assign w_start = (r_fsm == U_READY) && (state == S_CAL);
    assign w_abort = (state == S_INIT);
    assign w_div0  = (r_op == OP_DIV) && (r_b == '0);

    // add/sub and divide-by-zero finish on the first busy edge; mul/div
    // finish on the W-th busy edge.
    assign w_last = (r_op == OP_ADD) || (r_op == OP_SUB) || w_div0 ||
                    (r_cnt == CW'(W - 1));

    assign w_sum  = {1'b0, r_x[W-1:0]} + {1'b0, r_b};
    assign w_diff = {{W{1'b0}}, r_x[W-1:0]} - {{W{1'b0}}, r_b};

    assign w_acc_next = r_acc + (r_y[0] ? r_x : '0);

    // Restoring step: bring down the next dividend bit, try the subtract and
    // keep it only if it did not borrow (MSB of the W+1-bit trial clear).
    assign w_rem_sh   = {r_rem, r_y[W-1]};
    assign w_trial    = w_rem_sh - {1'b0, r_b};
    assign w_qbit     = ~w_trial[W];
    assign w_rem_next = w_qbit ? w_trial[W-1:0] : w_rem_sh[W-1:0];
    assign w_q_next   = {r_y[W-2:0], w_qbit};

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fsm <= U_IDLE;
        end else begin
            r_fsm <= w_fsm_next;
        end
    end

    // FSM next state
    always_comb begin
        w_fsm_next = r_fsm;
        case (r_fsm)
            U_IDLE:  w_fsm_next = U_READY;
            U_READY: if (w_start) w_fsm_next = U_BUSY;
            U_BUSY: begin
                if (w_abort) begin
                    w_fsm_next = U_READY;
                end else if (w_last) begin
                    w_fsm_next = U_DONE;
                end
            end
            U_DONE:  if (w_abort) w_fsm_next = U_READY;
            default: w_fsm_next = U_IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op     <= '0;
            r_b      <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_acc    <= '0;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_start) begin
                r_op  <= op;
                r_b   <= b;
                r_x   <= {{W{1'b0}}, a};
                r_y   <= (op == OP_DIV) ? a : b;
                r_acc <= '0;
                r_rem <= '0;
                r_cnt <= '0;
                r_err <= 1'b0;
            end else if ((r_fsm == U_BUSY) && !w_abort) begin
                case (r_op)
                    OP_ADD: r_result <= {{(W-1){1'b0}}, w_sum};
                    OP_SUB: r_result <= w_diff;
                    OP_MUL: begin
                        r_acc <= w_acc_next;
                        r_x   <= r_x << 1;
                        r_y   <= r_y >> 1;
                        r_cnt <= r_cnt + 1'b1;
                        if (w_last) r_result <= w_acc_next;
                    end
                    default: begin
                        if (w_div0) begin
                            r_result <= '1;
                            r_err    <= 1'b1;
                        end else begin
                            r_rem <= w_rem_next;
                            r_y   <= w_q_next;
                            r_cnt <= r_cnt + 1'b1;
                            if (w_last) r_result <= {w_rem_next, w_q_next};
                        end
                    end
                endcase
            end
        end
    end

    assign CS     = r_fsm;
    assign result = r_result;
    assign err    = r_err;

endmodule
